// File: rtl/multicore_pkg.sv
// Shared constants and sequencer state type for the multicore reset sequencer / output arbiter.
package multicore_pkg;

    localparam int unsigned N_CORES_DEF = 26;
    localparam int unsigned DATA_W_DEF  = 31;
    localparam int unsigned EN_W_DEF    = 4;
    localparam int unsigned STAGGER_DEF = 17;

    typedef enum logic {
        SEQ = 1'b0,
        RUN = 1'b1
    } seq_state_t;

endpackage

// File: rtl/multicore_seq_arb_rr_arbiter.sv
// Combinational round-robin arbiter: searches from rr_ptr+1 (mod N) and grants the first requester.
module rr_arbiter #(
    parameter int unsigned N     = 26,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int unsigned pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = (32'(rr_ptr) + k) % N;
            if (!any && req[IDX_W'(pos)]) begin
                any       = 1'b1;
                grant_idx = IDX_W'(pos);
                grant     = N'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/multicore_seq_arb.sv
// Staggered per-core reset release plus round-robin merge of core outputs onto one registered port.
// Optional collision flag/counter enabled by defining ARB_COLLISION_EN.
module multicore_seq_arb
    import multicore_pkg::*;
#(
    parameter int unsigned N_CORES = N_CORES_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned EN_W    = EN_W_DEF,
    parameter int unsigned STAGGER = STAGGER_DEF,
    parameter int unsigned IDX_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [N_CORES-1:0]          core_rst,
    input  logic [N_CORES*DATA_W-1:0]   core_io_out,
    input  logic [N_CORES*EN_W-1:0]     core_out_en,
    output logic signed [DATA_W-1:0]    io_out,
    output logic [EN_W-1:0]             out_en,
    output logic                        out_valid,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        all_up
`ifdef ARB_COLLISION_EN
    ,
    output logic                        collision,
    output logic [15:0]                 collision_cnt
`endif
);

    localparam int unsigned CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    seq_state_t                 state;
    logic [IDX_W-1:0]           ptr;
    logic [CNT_W-1:0]           cnt;
    logic [IDX_W-1:0]           rr_ptr;
    logic [N_CORES-1:0]         req;
    logic [N_CORES-1:0]         grant;
    logic [IDX_W-1:0]           win_idx;
    logic                       any;
    logic signed [DATA_W-1:0]   win_data;
    logic [EN_W-1:0]            win_en;

    // Cores still held in reset never request.
    always_comb begin
        req = '0;
        for (int i = 0; i < N_CORES; i++) begin
            req[i] = !core_rst[i] && (core_out_en[i*EN_W +: EN_W] != '0);
        end
    end

    rr_arbiter #(.N(N_CORES), .IDX_W(IDX_W)) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .any       (any)
    );

    always_comb begin
        win_data = '0;
        win_en   = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (grant[i]) begin
                win_data = core_io_out[i*DATA_W +: DATA_W];
                win_en   = core_out_en[i*EN_W +: EN_W];
            end
        end
    end

`ifdef ARB_COLLISION_EN
    logic multi_req;
    assign multi_req = |(req & (req - N_CORES'(1)));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEQ;
            ptr       <= '0;
            cnt       <= '0;
            core_rst  <= '1;
            all_up    <= 1'b0;
            rr_ptr    <= IDX_W'(N_CORES - 1);
            io_out    <= '0;
            out_en    <= '0;
            out_valid <= 1'b0;
            grant_idx <= '0;
`ifdef ARB_COLLISION_EN
            collision     <= 1'b0;
            collision_cnt <= '0;
`endif
        end else begin
            // Release sequencer: one core per STAGGER-cycle slot, released on the slot's first cycle.
            case (state)
                SEQ: begin
                    if (cnt == '0) core_rst[ptr] <= 1'b0;
                    if (cnt == CNT_W'(STAGGER - 1)) begin
                        cnt <= '0;
                        if (ptr == IDX_W'(N_CORES - 1)) begin
                            state  <= RUN;
                            all_up <= 1'b1;
                        end else begin
                            ptr <= ptr + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: all_up <= 1'b1;
            endcase

            io_out    <= win_data;
            out_en    <= win_en;
            out_valid <= any;
            if (any) begin
                grant_idx <= win_idx;
                rr_ptr    <= win_idx;
            end
`ifdef ARB_COLLISION_EN
            collision <= multi_req;
            if (multi_req && collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
`endif
        end
    end

endmodule

// File: tb/tb_multicore_seq_arb.sv
// Directed self-checking bench for multicore_seq_arb at default parameters.
module tb_multicore_seq_arb;
    import multicore_pkg::*;

    localparam int unsigned N  = N_CORES_DEF;
    localparam int unsigned DW = DATA_W_DEF;
    localparam int unsigned EW = EN_W_DEF;
    localparam int unsigned ST = STAGGER_DEF;
    localparam int unsigned IW = $clog2(N_CORES_DEF);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           core_rst;
    logic [N*DW-1:0]        core_io_out;
    logic [N*EW-1:0]        core_out_en;
    logic signed [DW-1:0]   io_out;
    logic [EW-1:0]          out_en;
    logic                   out_valid;
    logic [IW-1:0]          grant_idx;
    logic                   all_up;
`ifdef ARB_COLLISION_EN
    logic                   collision;
    logic [15:0]            collision_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicore_seq_arb dut (
        .clk         (clk),
        .rst         (rst),
        .core_rst    (core_rst),
        .core_io_out (core_io_out),
        .core_out_en (core_out_en),
        .io_out      (io_out),
        .out_en      (out_en),
        .out_valid   (out_valid),
        .grant_idx   (grant_idx),
        .all_up      (all_up)
`ifdef ARB_COLLISION_EN
        ,
        .collision     (collision),
        .collision_cnt (collision_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic signed [DW-1:0] d, input logic [EW-1:0] e);
        core_io_out[i*DW +: DW] = d;
        core_out_en[i*EW +: EW] = e;
    endtask

    // Core i is held in reset until edge i*ST+1 after rst drops.
    function automatic logic [N-1:0] rst_model(input int c);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = !(c >= i * int'(ST) + 1);
        return m;
    endfunction

    task automatic release_run();
        for (int c = 1; c <= 450; c++) begin
            tick();
            check("core_rst", 64'(core_rst), 64'(rst_model(c)));
            check("all_up", 64'(all_up), 64'(c >= int'(N * ST)));
        end
    endtask

    initial begin
        int rr_seq[3];
        int wrap_seq[4];
        rr_seq   = '{3, 7, 20};
        wrap_seq = '{25, 0, 25, 0};

        rst         = 1'b1;
        core_io_out = '0;
        core_out_en = '0;
        tick();
        tick();
        check("rst_core_rst", 64'(core_rst), 64'({N{1'b1}}));
        check("rst_io_out", 64'(io_out), 64'(0));
        check("rst_out_en", 64'(out_en), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_gidx", 64'(grant_idx), 64'(0));
        check("rst_all_up", 64'(all_up), 64'(0));

        // Core 5 requests from cycle 20 but may only win once released.
        rst = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            check("seq_core_rst", 64'(core_rst), 64'(rst_model(c)));
            check("gate_valid", 64'(out_valid), 64'(c >= 5 * int'(ST) + 2));
            if (c >= 5 * int'(ST) + 2) begin
                check("gate_gidx", 64'(grant_idx), 64'(5));
                check("gate_data", 64'(io_out), 64'(DW'(55)));
            end
            if (c == 20) drive(5, DW'(55), EW'(1));
        end

        // Mid-sequence reset with a live request: reset wins.
        rst = 1'b1;
        tick();
        check("mid_rst_core_rst", 64'(core_rst), 64'({N{1'b1}}));
        check("mid_rst_all_up", 64'(all_up), 64'(0));
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_gidx", 64'(grant_idx), 64'(0));
        rst = 1'b0;
        drive(5, '0, '0);
        release_run();

        // Round-robin among three persistent requesters.
        drive(3, DW'(3), EW'(1));
        drive(7, DW'(7), EW'(1));
        drive(20, DW'(20), EW'(1));
        for (int k = 0; k < 9; k++) begin
            tick();
            check("rr_data", 64'(io_out), 64'(DW'(rr_seq[k % 3])));
            check("rr_gidx", 64'(grant_idx), 64'(rr_seq[k % 3]));
            check("rr_valid", 64'(out_valid), 64'(1));
            check("rr_en", 64'(out_en), 64'(1));
        end
        drive(3, '0, '0);
        drive(7, '0, '0);
        drive(20, '0, '0);
        tick();
        check("idle_valid", 64'(out_valid), 64'(0));
        check("idle_data", 64'(io_out), 64'(0));
        check("idle_en", 64'(out_en), 64'(0));
        check("idle_gidx_hold", 64'(grant_idx), 64'(20));

        // Wrap-around from pointer 20: core 25 before core 0.
        drive(0, DW'(12345), EW'(4'h3));
        drive(25, DW'(-1000), EW'(4'hA));
        for (int k = 0; k < 4; k++) begin
            tick();
            check("wrap_gidx", 64'(grant_idx), 64'(wrap_seq[k]));
            check("wrap_data", 64'(io_out), (wrap_seq[k] == 0) ? 64'(DW'(12345)) : 64'(DW'(-1000)));
            check("wrap_en", 64'(out_en), (wrap_seq[k] == 0) ? 64'(4'h3) : 64'(4'hA));
        end
        drive(0, '0, '0);
        drive(25, '0, '0);
        tick();
        check("wrap_idle_valid", 64'(out_valid), 64'(0));

        // Single-cycle request: one-cycle latency, then idle.
        drive(0, DW'(-5), EW'(1));
        tick();
        check("lat_data", 64'(io_out), 64'(DW'(-5)));
        check("lat_en", 64'(out_en), 64'(1));
        check("lat_valid", 64'(out_valid), 64'(1));
        check("lat_gidx", 64'(grant_idx), 64'(0));
        drive(0, '0, '0);
        tick();
        check("lat_idle_valid", 64'(out_valid), 64'(0));
        check("lat_idle_data", 64'(io_out), 64'(0));
        check("lat_idle_gidx", 64'(grant_idx), 64'(0));

`ifdef ARB_COLLISION_EN
        rst = 1'b1;
        tick();
        check("col_rst_cnt", 64'(collision_cnt), 64'(0));
        rst = 1'b0;
        release_run();
        drive(1, DW'(1), EW'(1));
        drive(2, DW'(2), EW'(1));
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("col_flag", 64'(collision), 64'(1));
            check("col_cnt", 64'(collision_cnt), 64'(k));
        end
        drive(1, '0, '0);
        drive(2, '0, '0);
        tick();
        check("col_flag_idle", 64'(collision), 64'(0));
        check("col_cnt_hold", 64'(collision_cnt), 64'(3));
        drive(1, DW'(1), EW'(1));
        drive(2, DW'(2), EW'(1));
        for (int k = 0; k < 70000; k++) tick();
        check("col_sat", 64'(collision_cnt), 64'(16'hFFFF));
        check("col_sat_flag", 64'(collision), 64'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicore_seq_arb.md
Name: multicore_seq_arb

Overview:
- Parametrised reset sequencer and output arbiter for an array of N identical rede cores sharing one io_in bus.
- Releases core resets one at a time, STAGGER cycles apart.
- Merges the per-core io_out/out_en streams onto one registered output through a round-robin arbiter. This replaces the fixed 26-core priority mux.
- Sits between the rede instances and the top-level I/O; the wrapper instantiates the cores and connects the flattened buses.

Parameters:
- N_CORES, 26, number of cores (1..256).
- DATA_W, 31, width of each core's io_out (signed).
- EN_W, 4, width of each core's out_en.
- STAGGER, 17, cycles between consecutive core reset releases (>=1).
- IDX_W, $clog2(N_CORES) (min 1), derived; width of the core index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- core_rst  out  N_CORES  per-core reset, bit i drives rede i; 1 = held in reset.
- core_io_out  in  N_CORES*DATA_W  flattened core outputs; core i at [i*DATA_W +: DATA_W].
- core_out_en  in  N_CORES*EN_W  flattened core out_en; core i at [i*EN_W +: EN_W].
- io_out  out  DATA_W  arbitrated data (signed).
- out_en  out  EN_W  out_en of the granted core; 0 when idle.
- out_valid  out  1  io_out/out_en hold a granted word this cycle.
- grant_idx  out  IDX_W  index of the core granted in the current output word.
- all_up  out  1  every core has been released from reset.

Behaviour:
- Reset: synchronous, active-high, one clock.
  - While rst=1 at a clock edge: core_rst all ones, io_out=0, out_en=0, out_valid=0, grant_idx=0, all_up=0, FSM=SEQ, core pointer=0, stagger counter=0, round-robin pointer=N_CORES-1.
  - rst asserted mid-operation re-asserts every core_rst on the next edge and restarts the whole sequence.
- Sequencer FSM, states SEQ and RUN:
  - SEQ: core_rst[ptr] is cleared on the first cycle of each slot. The counter counts 0..STAGGER-1.
  - At STAGGER-1, the counter clears and ptr increments. If ptr==N_CORES-1, the FSM goes to RUN instead.
  - Core i is released at cycle i*STAGGER+1 after rst deasserts.
  - RUN: terminal state. all_up=1, registered, asserted on the edge that enters RUN. A released core is never re-reset except by rst.
- Request definition: req[i] = !core_rst[i] && (core_out_en slice i != 0). Cores still held in reset never request.
- Arbitration, round-robin:
  - Search starts at rr_ptr+1 (mod N_CORES) and grants the first requesting core.
  - On a grant, rr_ptr takes the granted index.
  - With no request, rr_ptr is unchanged.
  - A single persistent requester is granted every cycle.
- Output latency: 1 cycle.
  - The grant decided in cycle t appears on io_out/out_en/grant_idx/out_valid in cycle t+1.
  - io_out and out_en are copied unmodified from the winner.
  - With no request: out_valid=0, out_en=0, io_out=0, grant_idx holds its last value.
- Losers are not buffered. A core whose request is not granted must keep it asserted, per the rede output protocol. The block only selects and does not store.
- Boundary cases:
  - N_CORES=1: rr search degenerates to core 0; IDX_W=1.
  - STAGGER=1: one core released per cycle.
  - Simultaneous rst and request: rst wins.

Optional Feature:
- Macro ARB_COLLISION_EN.
- Defined: adds outputs collision (1 bit) and collision_cnt (16 bits).
  - collision is registered and aligned with out_valid. It is 1 when two or more requests were present in the arbitration cycle.
  - collision_cnt increments on each collision, saturates at 16'hFFFF, and is cleared by rst.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package multicore_pkg holds:
  - default constants N_CORES_DEF=26, DATA_W_DEF=31, EN_W_DEF=4, STAGGER_DEF=17;
  - typedef seq_state_t {SEQ, RUN}.
- One natural sub-module: rr_arbiter (parameter N). Inputs: req vector, rr_ptr. Outputs: grant one-hot, grant index, any.
  - Purely combinational.
  - The pointer register stays in multicore_seq_arb.

Test Plan:
- Release sequence: N_CORES=26, STAGGER=17; deassert rst, count cycles.
  - core_rst[0] clears at cycle 1, core_rst[1] at cycle 18, core_rst[25] at cycle 426.
  - all_up=1 one slot later.
  - core_rst is monotonic.
- Reset during release: assert rst at cycle 100, hold 1 cycle.
  - Next edge: core_rst=all ones, all_up=0.
  - Release restarts, core_rst[0] clearing 1 cycle after rst drops.
- Round-robin fairness: after all_up, cores 3, 7 and 20 hold out_en=4'd1 continuously with data 3, 7, 20.
  - io_out cycles 3, 7, 20, 3, ...
  - out_valid=1 every cycle, grant_idx matches the data.
- Reset gating: at cycle 20, core 5 (still in reset) drives out_en=1.
  - out_valid stays 0.
  - Core 5 is granted only after core_rst[5] clears.
- Idle and latency: one request from core 0, data -5, lasting one cycle.
  - Next cycle: io_out=-5, out_en=1, out_valid=1.
  - The cycle after: out_valid=0, io_out=0, grant_idx=0.
- Collision (ARB_COLLISION_EN): cores 1 and 2 request together for 3 cycles.
  - collision=1 for 3 cycles and collision_cnt=3.
  - Saturation is checked by forcing 70000 collisions: collision_cnt=16'hFFFF.
